// File: rtl/nes_pad_reader.sv
// NES-style gamepad serial reader: generates latch/clock pulses, shifts in 8 active-low
// button bits per frame and publishes the button byte plus pressed/released edge masks.
// Optional event FIFO enabled by defining NES_EVENT_FIFO_EN.
module nes_pad_reader #(
  parameter int CLK_DIV    = 150,
  parameter int POLL_GAP   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        poll_en,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clock,
  output logic [7:0]  buttons,
  output logic        frame_valid,
  output logic [7:0]  pressed,
  output logic [7:0]  released,
  input  logic        evt_rd,
  output logic [15:0] evt_dout,
  output logic        evt_empty,
  output logic        evt_ovf,
  input  logic        evt_ovf_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SAMPLE,
    ST_CLK,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg;
  logic               tick;
  logic [7:0]         shift_reg, shift_next;
  logic [2:0]         bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               pad_latch_reg, pad_clock_reg;
  logic [7:0]         buttons_reg;
  logic               frame_valid_reg;
  logic [7:0]         pressed_reg, released_reg;
  logic               done;
  logic [7:0]         pressed_new, released_new;

  assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tick && poll_en) begin
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (tick) begin
          state_next   = ST_SAMPLE;
          bit_cnt_next = '0;
        end
      end
      ST_SAMPLE: begin
        // Pad drives active-low data; store it active-high, first bit ends up in [7]
        if (tick) begin
          shift_next   = {shift_reg[6:0], ~pad_data};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          state_next   = (bit_cnt_reg == 3'd7) ? ST_DONE : ST_CLK;
        end
      end
      ST_CLK: begin
        if (tick) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_DONE: begin
        gap_cnt_next = '0;
        state_next   = (POLL_GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (tick) begin
          if (int'(gap_cnt_reg) >= POLL_GAP - 1) begin
            state_next = ST_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pins are decoded from the next state so they toggle exactly with the state register
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pad_latch_reg <= 1'b0;
      pad_clock_reg <= 1'b0;
    end else begin
      pad_latch_reg <= (state_next == ST_LATCH);
      pad_clock_reg <= (state_next == ST_CLK);
    end
  end

  assign done         = (state_reg == ST_DONE);
  assign pressed_new  = shift_reg & ~buttons_reg;
  assign released_new = ~shift_reg & buttons_reg;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      buttons_reg     <= '0;
      frame_valid_reg <= 1'b0;
      pressed_reg     <= '0;
      released_reg    <= '0;
    end else begin
      frame_valid_reg <= done;
      pressed_reg     <= done ? pressed_new : 8'h00;
      released_reg    <= done ? released_new : 8'h00;
      if (done) begin
        buttons_reg <= shift_reg;
      end
    end
  end

  assign pad_latch   = pad_latch_reg;
  assign pad_clock   = pad_clock_reg;
  assign buttons     = buttons_reg;
  assign frame_valid = frame_valid_reg;
  assign pressed     = pressed_reg;
  assign released    = released_reg;

`ifdef NES_EVENT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop, drop;

  assign fifo_full  = (count_reg == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push_req   = done && ({pressed_new, released_new} != 16'h0000);
  assign pop        = evt_rd && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {pressed_new, released_new};
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (evt_ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign evt_dout  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_reg];
  assign evt_empty = fifo_empty;
  assign evt_ovf   = ovf_reg;
`else
  logic unused_fifo_inputs;

  assign unused_fifo_inputs = ^{evt_rd, evt_ovf_clr, 1'(FIFO_DEPTH)};
  assign evt_dout  = 16'h0000;
  assign evt_empty = 1'b1;
  assign evt_ovf   = 1'b0;
`endif

endmodule
